// File: rtl/store_sched_pkg.sv
// Shared types and defaults for the D-cache port scheduler between loads and
// the store-queue drain.
package store_sched_pkg;

    localparam int PTR_W          = 5;
    localparam int DEF_DEPTH      = 16;
    localparam int DEF_HI_WATER   = 12;
    localparam int DEF_STARVE_MAX = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LD_BUSY = 2'd1,
        ST_BUSY = 2'd2
    } state_e;

endpackage

// File: rtl/store_ptr_track.sv
// Commit/drain pointer pair for the store queue: pending count, commit
// legality against the executed-store count, and the sticky illegal-commit flag.
module store_ptr_track
    import store_sched_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PTR_W-1:0] store_exe_num_i,
    input  logic             rob_st_cmt_i,
    input  logic             drain_ack_i,
    output logic [3:0]       drain_idx_o,
    output logic [PTR_W-1:0] st_pending_o,
    output logic             cmt_err_o
);

    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

    logic [PTR_W-1:0] cmt_ptr_q, cmt_ptr_d;
    logic [PTR_W-1:0] drain_ptr_q, drain_ptr_d;
    logic             cmt_err_q, cmt_err_d;
    logic [PTR_W-1:0] exe_gap;
    logic             cmt_legal;

    // All pointer arithmetic is mod 32; wrap needs no special case.
    assign st_pending_o = cmt_ptr_q - drain_ptr_q;
    assign exe_gap      = store_exe_num_i - cmt_ptr_q;
    assign cmt_legal    = rob_st_cmt_i && (exe_gap != '0) && (st_pending_o < DEPTH_P);

    always_comb begin
        cmt_ptr_d   = cmt_ptr_q;
        drain_ptr_d = drain_ptr_q;
        cmt_err_d   = cmt_err_q;
        if (cmt_legal) begin
            cmt_ptr_d = cmt_ptr_q + 1'b1;
        end else if (rob_st_cmt_i) begin
            cmt_err_d = 1'b1;
        end
        if (drain_ack_i) begin
            drain_ptr_d = drain_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmt_ptr_q   <= '0;
            drain_ptr_q <= '0;
            cmt_err_q   <= 1'b0;
        end else begin
            cmt_ptr_q   <= cmt_ptr_d;
            drain_ptr_q <= drain_ptr_d;
            cmt_err_q   <= cmt_err_d;
        end
    end

    assign drain_idx_o = drain_ptr_q[3:0];
    assign cmt_err_o   = cmt_err_q;

endmodule

// File: rtl/store_drain_sched.sv
// Arbitrates the single D-cache port between load requests and store-queue
// drains, with high-water, starvation-limit and drain-all overrides.
module store_drain_sched
    import store_sched_pkg::*;
#(
    parameter int DEPTH      = DEF_DEPTH,
    parameter int HI_WATER   = DEF_HI_WATER,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PTR_W-1:0] store_exe_num,
    input  logic             rob_st_cmt,
    input  logic             ld_req,
    input  logic             drain_all,
    input  logic             dc_ack,
    output logic             ld_gnt,
    output logic             dc_req,
    output logic             dc_we,
    output logic [3:0]       stq_rd_idx,
    output logic [PTR_W-1:0] st_pending,
    output logic             sq_empty,
    output logic             cmt_err,
    output state_e           dbg_state
);

    localparam int               SC_W       = $clog2(STARVE_MAX + 1);
    localparam logic [SC_W-1:0]  STARVE_LIM = SC_W'(STARVE_MAX);
    localparam logic [PTR_W-1:0] HI_WATER_P = PTR_W'(HI_WATER);

    state_e          state_q, state_d;
    logic            ld_gnt_q, ld_gnt_d;
    logic            dc_req_q, dc_req_d;
    logic            dc_we_q, dc_we_d;
    logic [SC_W-1:0] starve_cnt_q, starve_cnt_d;
    logic            st_sel;
    logic            drain_ack;

    assign drain_ack = (state_q == ST_BUSY) && dc_ack;

    store_ptr_track #(
        .DEPTH (DEPTH)
    ) u_ptr (
        .clk             (clk),
        .reset           (reset),
        .store_exe_num_i (store_exe_num),
        .rob_st_cmt_i    (rob_st_cmt),
        .drain_ack_i     (drain_ack),
        .drain_idx_o     (stq_rd_idx),
        .st_pending_o    (st_pending),
        .cmt_err_o       (cmt_err)
    );

    assign sq_empty = (st_pending == '0);
    assign st_sel   = !sq_empty && (drain_all || (st_pending >= HI_WATER_P) ||
                                    (starve_cnt_q >= STARVE_LIM) || !ld_req);

    // Handshake: dc_req rises one cycle after the IDLE decision and holds until
    // the cycle dc_ack is seen; dc_ack in IDLE is ignored. One IDLE cycle
    // always separates accesses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            ld_gnt_q     <= 1'b0;
            dc_req_q     <= 1'b0;
            dc_we_q      <= 1'b0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            ld_gnt_q     <= ld_gnt_d;
            dc_req_q     <= dc_req_d;
            dc_we_q      <= dc_we_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (st_sel) begin
                    state_d = ST_BUSY;
                end else if (ld_req) begin
                    state_d = LD_BUSY;
                end
            end
            LD_BUSY, ST_BUSY: begin
                if (dc_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ld_gnt_d     = 1'b0;
        dc_req_d     = dc_req_q;
        dc_we_d      = dc_we_q;
        starve_cnt_d = starve_cnt_q;
        case (state_q)
            IDLE: begin
                if (st_sel) begin
                    dc_req_d     = 1'b1;
                    dc_we_d      = 1'b1;
                    starve_cnt_d = '0;
                end else if (ld_req) begin
                    ld_gnt_d = 1'b1;
                    dc_req_d = 1'b1;
                    dc_we_d  = 1'b0;
                    // Only loads that bypass waiting stores count toward starvation.
                    if (sq_empty) begin
                        starve_cnt_d = '0;
                    end else if (starve_cnt_q < STARVE_LIM) begin
                        starve_cnt_d = starve_cnt_q + 1'b1;
                    end
                end
            end
            LD_BUSY, ST_BUSY: begin
                if (dc_ack) begin
                    dc_req_d = 1'b0;
                    dc_we_d  = 1'b0;
                end
            end
            default: begin
                dc_req_d = 1'b0;
                dc_we_d  = 1'b0;
            end
        endcase
    end

    assign ld_gnt    = ld_gnt_q;
    assign dc_req    = dc_req_q;
    assign dc_we     = dc_we_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_store_drain_sched.sv
// Directed bench for store_drain_sched: store indices are queued at commit time
// and compared when the matching drain access appears on the D-cache port.
module tb_store_drain_sched;
    import store_sched_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] store_exe_num = '0;
    logic       rob_st_cmt = 1'b0;
    logic       ld_req = 1'b0;
    logic       drain_all = 1'b0;
    logic       dc_ack = 1'b0;
    logic       ld_gnt, dc_req, dc_we, sq_empty, cmt_err;
    logic [3:0] stq_rd_idx;
    logic [4:0] st_pending;
    state_e     dbg_state;

    int         n_checks = 0;
    int         n_fail = 0;
    int         gnt_cnt = 0;
    logic [3:0] exp_q[$];
    logic [4:0] m_cmt = '0;
    logic [4:0] m_drain = '0;

    always #5 clk = ~clk;

    store_drain_sched dut (
        .clk           (clk),
        .reset         (reset),
        .store_exe_num (store_exe_num),
        .rob_st_cmt    (rob_st_cmt),
        .ld_req        (ld_req),
        .drain_all     (drain_all),
        .dc_ack        (dc_ack),
        .ld_gnt        (ld_gnt),
        .dc_req        (dc_req),
        .dc_we         (dc_we),
        .stq_rd_idx    (stq_rd_idx),
        .st_pending    (st_pending),
        .sq_empty      (sq_empty),
        .cmt_err       (cmt_err),
        .dbg_state     (dbg_state)
    );

    always @(posedge clk) begin
        #1;
        if (ld_gnt === 1'b1) gnt_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit model_legal();
        logic [4:0] gap;
        logic [4:0] pend;
        gap  = store_exe_num - m_cmt;
        pend = m_cmt - m_drain;
        return (gap != 5'd0) && (pend < 5'd16);
    endfunction

    // One commit strobe per cycle; legal ones queue the index they will drain from.
    task automatic commit(input int n);
        for (int i = 0; i < n; i++) begin
            rob_st_cmt = 1'b1;
            if (model_legal()) begin
                exp_q.push_back(m_cmt[3:0]);
                m_cmt = m_cmt + 5'd1;
            end
            @(negedge clk);
        end
        rob_st_cmt = 1'b0;
    endtask

    // Waits for an access, checks it, optionally commits while it is outstanding, then acks.
    task automatic serve(input int n_cmt, input bit cmt_on_ack, output bit we);
        bit legal;
        we = 1'b0;
        for (int i = 0; i < 40 && dc_req !== 1'b1; i++) @(negedge clk);
        check("access_seen", dc_req, 1);
        if (dc_req !== 1'b1) return;
        we = dc_we;
        check("busy_state", dbg_state, we ? ST_BUSY : LD_BUSY);
        if (we) begin
            check("store_queued", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("stq_rd_idx", stq_rd_idx, exp_q.pop_front());
        end else begin
            check("ld_gnt_with_req", ld_gnt, 1);
        end
        for (int i = 0; i < n_cmt; i++) begin
            rob_st_cmt = 1'b1;
            if (model_legal()) begin
                exp_q.push_back(m_cmt[3:0]);
                m_cmt = m_cmt + 5'd1;
            end
            @(negedge clk);
        end
        rob_st_cmt = 1'b0;
        check("req_held", dc_req, 1);
        dc_ack = 1'b1;
        rob_st_cmt = cmt_on_ack;
        legal = cmt_on_ack && model_legal();
        if (legal) begin
            exp_q.push_back(m_cmt[3:0]);
            m_cmt = m_cmt + 5'd1;
        end
        if (we) m_drain = m_drain + 5'd1;
        @(negedge clk);
        dc_ack = 1'b0;
        rob_st_cmt = 1'b0;
        check("req_drop", dc_req, 0);
    endtask

    initial begin
        bit         we;
        int         g0;
        int         k;
        logic [4:0] rem;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        check("rst_ld_gnt", ld_gnt, 0);
        check("rst_dc_req", dc_req, 0);
        check("rst_dc_we", dc_we, 0);
        check("rst_idx", stq_rd_idx, 0);
        check("rst_pending", st_pending, 0);
        check("rst_sq_empty", sq_empty, 1);
        check("rst_cmt_err", cmt_err, 0);
        check("rst_state", dbg_state, IDLE);
        reset = 1'b1;
        @(negedge clk);

        // 1: three commits drain in order 0,1,2
        store_exe_num = 5'd3;
        commit(3);
        check("t1_pending3", st_pending, 3);
        for (int i = 0; i < 3; i++) begin
            serve(0, 0, we);
            check("t1_store", we, 1);
        end
        check("t1_pending0", st_pending, 0);
        check("t1_sq_empty", sq_empty, 1);
        check("t1_queue_drained", exp_q.size(), 0);

        // 2: commit with nothing executed is illegal and sticky
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        m_cmt = '0;
        m_drain = '0;
        exp_q.delete();
        store_exe_num = 5'd0;
        commit(1);
        check("t2_cmt_err", cmt_err, 1);
        check("t2_pending", st_pending, 0);
        repeat (3) @(negedge clk);
        check("t2_no_req", dc_req, 0);
        check("t2_err_sticky", cmt_err, 1);

        // 3: starvation limit forces a store after four bypassing loads
        store_exe_num = m_cmt + 5'd2;
        ld_req = 1'b1;
        serve(2, 0, we);
        check("t3_setup_load", we, 0);
        check("t3_pending2", st_pending, 2);
        for (int r = 0; r < 2; r++) begin
            g0 = gnt_cnt;
            for (int i = 0; i < 4; i++) begin
                serve(0, 0, we);
                check("t3_starve_load", we, 0);
            end
            serve(0, 0, we);
            check("t3_forced_store", we, 1);
            check("t3_gnt_count", gnt_cnt - g0, 4);
        end
        check("t3_pending0", st_pending, 0);

        // 4: high-water mark lets stores win until pending drops below it
        store_exe_num = m_cmt + 5'd12;
        serve(12, 0, we);
        check("t4_fill_load", we, 0);
        check("t4_pending12", st_pending, 12);
        serve(0, 0, we);
        check("t4_hw_store", we, 1);
        check("t4_pending11", st_pending, 11);
        serve(0, 0, we);
        check("t4_load_after_hw", we, 0);
        ld_req = 1'b0;
        for (int i = 0; i < 11; i++) begin
            serve(0, 0, we);
            check("t4_drain_store", we, 1);
        end
        check("t4_sq_empty", sq_empty, 1);

        // 5: drain_all holds loads off until the queue is empty
        drain_all = 1'b1;
        ld_req = 1'b1;
        store_exe_num = m_cmt + 5'd5;
        serve(5, 0, we);
        check("t5_empty_fence_load", we, 0);
        check("t5_pending5", st_pending, 5);
        g0 = gnt_cnt;
        for (int i = 0; i < 5; i++) begin
            serve(0, 0, we);
            check("t5_fence_store", we, 1);
        end
        check("t5_no_gnt", gnt_cnt - g0, 0);
        check("t5_sq_empty", sq_empty, 1);
        serve(0, 0, we);
        check("t5_load_after_fence", we, 0);
        drain_all = 1'b0;
        ld_req = 1'b0;

        // 6: walk pointers to 30, then commit+ack together across the wrap
        while (m_cmt != 5'd30) begin
            rem = 5'd30 - m_cmt;
            k = (rem > 5'd8) ? 8 : int'(rem);
            store_exe_num = m_cmt + 5'(k);
            commit(k);
            for (int i = 0; i < k; i++) begin
                serve(0, 0, we);
                check("t6_walk_store", we, 1);
            end
        end
        check("t6_pending0", st_pending, 0);
        store_exe_num = m_cmt + 5'd8;
        commit(1);
        for (int i = 0; i < 3; i++) begin
            serve(0, 1, we);
            check("t6_wrap_store", we, 1);
            check("t6_wrap_pending", st_pending, 1);
        end

        // Reset in the middle of the drain of index 1
        for (int i = 0; i < 40 && dc_req !== 1'b1; i++) @(negedge clk);
        check("t6_last_access", dc_req, 1);
        check("t6_last_we", dc_we, 1);
        check("t6_last_queued", exp_q.size(), 1);
        if (exp_q.size() > 0) check("t6_last_idx", stq_rd_idx, exp_q.pop_front());
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_dc_req", dc_req, 0);
        check("mid_rst_dc_we", dc_we, 0);
        check("mid_rst_idx", stq_rd_idx, 0);
        check("mid_rst_pending", st_pending, 0);
        check("mid_rst_sq_empty", sq_empty, 1);
        check("mid_rst_state", dbg_state, IDLE);
        @(negedge clk);
        reset = 1'b1;
        m_cmt = '0;
        m_drain = '0;
        dc_ack = 1'b1;
        @(negedge clk);
        dc_ack = 1'b0;
        check("stale_ack_pending", st_pending, 0);
        check("stale_ack_req", dc_req, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
